milano_wb_regfile: RTL



---
 rtl/milano_pkg.sv | 25 ++
 rtl/milano_regfile_array.sv | 52 +++++
 rtl/milano_wb_regfile.sv | 90 +++++++++
 3 files changed

// File: rtl/milano_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | milano_pkg                                                           |
// | Shared types and sizes for the milano writeback stage.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package milano_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [0:0] {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/milano_regfile_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | milano_regfile_array                                                 |
// | 2R1W integer register storage, x0 reads as zero. Optional bypass of  |
// | the committing write onto the read ports: MILANO_REGFILE_FWD_EN.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module milano_regfile_array #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      waddr_i,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic [1:0][ADDR_W-1:0] raddr_i,
  output logic [1:0][DATA_W-1:0] rdata_o
);
  import milano_pkg::*;

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_wr_en;

  // x0 is never stored, so it never needs to be forwarded either
  assign w_wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    logic w_fwd;
`ifdef MILANO_REGFILE_FWD_EN
    assign w_fwd = w_wr_en && (raddr_i[p] == waddr_i);
`else
    assign w_fwd = 1'b0;
`endif
    assign rdata_o[p] = w_fwd               ? wdata_i :
                        (raddr_i[p] == '0)  ? '0      :
                                              r_mem[raddr_i[p]];
  end

endmodule
`default_nettype wire

// File: rtl/milano_wb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | milano_wb_regfile                                                    |
// | EX/WB latch with stall handshake, retire counter and register file.  |
// | Optional write-to-read bypass: MILANO_REGFILE_FWD_EN.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module milano_wb_regfile #(
  parameter int DATA_W   = milano_pkg::XLEN,
  parameter int ADDR_W   = milano_pkg::REG_ADDR_W,
  parameter int NUM_REGS = milano_pkg::NUM_REGS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              reg_we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] rd_wdata_i,
  input  logic              wb_stall_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_rdata_o,
  output logic [DATA_W-1:0] rs2_rdata_o,
  output logic              wb_valid_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [31:0]       retire_cnt_o
);
  import milano_pkg::*;

  wb_state_e r_state;
  wb_entry_t r_entry;
  logic [31:0] r_retire_cnt;

  logic w_accept;
  logic w_commit;
  logic [1:0][ADDR_W-1:0] w_raddr;
  logic [1:0][DATA_W-1:0] w_rdata;

  // A full latch can still take a new result when it drains on the same edge
  assign ex_ready_o = (r_state == WB_EMPTY) || !wb_stall_i;
  assign w_accept   = ex_valid_i && ex_ready_o;
  assign w_commit   = (r_state == WB_FULL) && !wb_stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= WB_EMPTY;
      r_entry      <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_commit) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
      if (w_accept) begin
        r_entry <= '{we: reg_we_i, addr: wr_addr_i, data: rd_wdata_i};
        r_state <= WB_FULL;
      end else if (w_commit) begin
        r_state <= WB_EMPTY;
      end
    end
  end

  assign wb_valid_o   = (r_state == WB_FULL);
  assign wb_we_o      = r_entry.we;
  assign wb_addr_o    = r_entry.addr;
  assign wb_data_o    = r_entry.data;
  assign retire_cnt_o = r_retire_cnt;

  assign w_raddr     = {rs2_addr_i, rs1_addr_i};
  assign rs1_rdata_o = w_rdata[0];
  assign rs2_rdata_o = w_rdata[1];

  milano_regfile_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (w_commit && r_entry.we),
    .waddr_i (r_entry.addr),
    .wdata_i (r_entry.data),
    .raddr_i (w_raddr),
    .rdata_o (w_rdata)
  );

endmodule
`default_nettype wire
